// File: rtl/io_load_stage.sv
// Load/result stage: formats memory read data per load type, flags misaligned loads, and
// presents one entry downstream. Left/right loads exist only when IO_LOAD_UNALIGNED_EN is defined.
module io_load_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allow_in,
  input  logic [ADDR_WIDTH-1:0]   in_program_count,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic                    in_is_load,
  input  logic [2:0]              in_load_type,
  input  logic                    in_unsigned,
  input  logic [4:0]              in_write_register,
  input  logic [DATA_WIDTH-1:0]   in_alu_result,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  input  logic                    flush,
  input  logic                    wb_allow_in,
  output logic                    out_valid,
  output logic [ADDR_WIDTH-1:0]   out_program_count,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [4:0]              out_write_register,
  output logic [DATA_WIDTH/8-1:0] out_write_strobe,
  output logic                    out_exception,
  output logic [ADDR_WIDTH-1:0]   out_badvaddr
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam logic [OFFW-1:0]  MaxOff  = OFFW'(BYTES - 1);
  localparam logic [BYTES-1:0] AllOnes = '1;

  localparam logic [2:0] LtWord   = 3'b000;
  localparam logic [2:0] LtHalf   = 3'b001;
  localparam logic [2:0] LtByte   = 3'b010;
  localparam logic [2:0] LtLeft   = 3'b011;
  localparam logic [2:0] LtRight  = 3'b100;
  localparam logic [2:0] LtDouble = 3'b101;

  typedef enum logic [1:0] {StEmpty, StWaitData, StHold} state_e;

  state_e                  state_q;
  logic                    discard_q, discard_d;
  logic [ADDR_WIDTH-1:0]   pc_q, addr_q;
  logic [2:0]              type_q;
  logic                    uns_q, is_load_q, exc_q;
  logic [4:0]              wreg_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic [2:0]              in_type_eff;
  logic                    in_misaligned;
  logic                    resp_take, fire;
  logic [DATA_WIDTH-1:0]   data_src, shifted_lo;
  logic [OFFW-1:0]         k, lshift;

  // Collapse types this build does not support onto a plain word load.
  function automatic logic [2:0] eff_type(input logic [2:0] t);
    logic [2:0] r;
    case (t)
      LtWord, LtHalf, LtByte: r = t;
`ifdef IO_LOAD_UNALIGNED_EN
      LtLeft, LtRight:        r = t;
`else
      LtLeft, LtRight:        r = LtWord;
`endif
      LtDouble:               r = (DATA_WIDTH == 64) ? LtDouble : LtWord;
      default:                r = LtWord;
    endcase
    return r;
  endfunction

  assign in_type_eff = eff_type(in_load_type);

  always_comb begin
    in_misaligned = 1'b0;
    case (in_type_eff)
      LtHalf:   in_misaligned = in_address[0];
      LtWord:   in_misaligned = (in_address[1:0] != 2'b00);
      LtDouble: in_misaligned = (in_address[2:0] != 3'b000);
      default:  in_misaligned = 1'b0;
    endcase
  end

  assign resp_take   = (state_q == StWaitData) & mem_resp_valid & ~discard_q;
  assign out_valid   = (state_q == StHold) | resp_take;
  assign in_allow_in = (state_q == StEmpty) | (out_valid & wb_allow_in);
  assign fire        = in_valid & in_allow_in & ~flush;

  // A flushed load still has a response in flight; remember to swallow it.
  always_comb begin
    discard_d = discard_q;
    if (mem_resp_valid && discard_q) discard_d = 1'b0;
    if (flush && state_q == StWaitData && !(mem_resp_valid && !discard_q)) discard_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StEmpty;
      discard_q <= 1'b0;
    end else begin
      discard_q <= discard_d;
      if (flush) begin
        state_q <= StEmpty;
      end else if (fire) begin
        state_q <= (in_is_load && !in_misaligned) ? StWaitData : StHold;
      end else if (resp_take && !wb_allow_in) begin
        state_q <= StHold;
      end else if (out_valid && wb_allow_in) begin
        state_q <= StEmpty;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      pc_q      <= in_program_count;
      addr_q    <= in_address;
      type_q    <= in_type_eff;
      uns_q     <= in_unsigned;
      is_load_q <= in_is_load;
      exc_q     <= in_is_load & in_misaligned;
      wreg_q    <= in_write_register;
      data_q    <= in_alu_result;
    end else if (resp_take && !wb_allow_in) begin
      data_q    <= mem_resp_data;
    end
  end

  assign data_src   = (state_q == StWaitData) ? mem_resp_data : data_q;
  assign k          = addr_q[OFFW-1:0];
  assign lshift     = MaxOff - k;
  // Aligned word/half/byte lanes all land at bit 0 after shifting by the byte offset.
  assign shifted_lo = data_src >> {k, 3'b000};

  always_comb begin
    out_result       = data_src;
    out_write_strobe = AllOnes;
    if (exc_q) begin
      out_write_strobe = '0;
    end else if (is_load_q) begin
      case (type_q)
        LtByte:   out_result = uns_q ? DATA_WIDTH'(shifted_lo[7:0])
                                     : DATA_WIDTH'(signed'(shifted_lo[7:0]));
        LtHalf:   out_result = uns_q ? DATA_WIDTH'(shifted_lo[15:0])
                                     : DATA_WIDTH'(signed'(shifted_lo[15:0]));
        LtWord:   out_result = DATA_WIDTH'(signed'(shifted_lo[31:0]));
        LtDouble: out_result = data_src;
`ifdef IO_LOAD_UNALIGNED_EN
        LtLeft: begin
          out_result       = data_src << {lshift, 3'b000};
          out_write_strobe = AllOnes << lshift;
        end
        LtRight: begin
          out_result       = shifted_lo;
          out_write_strobe = AllOnes >> k;
        end
`endif
        default:  out_result = data_src;
      endcase
    end
  end

  assign out_program_count  = pc_q;
  assign out_write_register = wreg_q;
  assign out_exception      = exc_q & out_valid;
  assign out_badvaddr       = (exc_q & out_valid) ? addr_q : '0;

endmodule

// File: doc/io_load_stage.md
IO_LOAD_STAGE -- requirements
Module: io_load_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath and memory word width; legal values 32 and 64; BYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning width of address and program count.
REQ-003 SHALL have ports (name direction width meaning); clock and reset listed first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  upstream entry valid.
- in_allow_in  out  1  stage can accept an entry this cycle.
- in_program_count  in  ADDR_WIDTH  entry PC.
- in_address  in  ADDR_WIDTH  memory address.
- in_is_load  in  1  entry reads memory.
- in_load_type  in  3  000 word, 001 half, 010 byte, 011 left, 100 right, 101 double (DATA_WIDTH=64 only).
- in_unsigned  in  1  zero-extend byte/half.
- in_write_register  in  5  destination register.
- in_alu_result  in  DATA_WIDTH  result for non-loads.
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  DATA_WIDTH  read data.
- flush  in  1  exception/eret flush from writeback.
- wb_allow_in  in  1  downstream accepts.
- out_valid  out  1  entry presented downstream.
- out_program_count  out  ADDR_WIDTH  entry PC.
- out_result  out  DATA_WIDTH  final result.
- out_write_register  out  5  destination.
- out_write_strobe  out  BYTES  byte write enables.
- out_exception  out  1  address-error load.
- out_badvaddr  out  ADDR_WIDTH  faulting address, else 0.

Function
REQ-004 SHALL use FSM states EMPTY, WAIT_DATA, HOLD.
REQ-005 SHALL set in_allow_in = (state==EMPTY) | (out_valid & wb_allow_in).
REQ-006 SHALL, on in_valid & in_allow_in & ~flush, register the entry; next state WAIT_DATA if in_is_load & no misalignment, else HOLD.
REQ-007 SHALL treat misalignment as: half addr[0]!=0; word addr[1:0]!=0; double addr[2:0]!=0; byte/left/right never misaligned.
REQ-008 SHALL, in WAIT_DATA, drive out_valid = mem_resp_valid (zero-latency bypass of mem_resp_data); if wb_allow_in low, capture data and enter HOLD.
REQ-009 SHALL, in HOLD, drive out_valid=1 with registered data until wb_allow_in, then EMPTY or the newly accepted entry's state.
REQ-010 SHALL extract byte/half lanes by address offset with sign extension unless in_unsigned; word in DATA_WIDTH=64 selected by addr[2] and sign-extended.
REQ-011 SHALL, for left with offset k=addr[log2(BYTES)-1:0], output data << ((BYTES-1-k)*8) and strobe = top k+1 bytes; for right, output data >> (k*8) and strobe = bottom BYTES-k bytes; all other types strobe all ones.
REQ-012 SHALL output in_alu_result for non-loads; on exception out_exception=1, out_badvaddr=in_address, out_write_strobe=0.
REQ-013 SHALL, on flush, clear to EMPTY next cycle regardless of state; flush with simultaneous in_valid drops the incoming entry.
REQ-014 SHALL, if flush hits WAIT_DATA before mem_resp_valid, set a discard flag that swallows exactly the next mem_resp_valid; in_allow_in stays 1 meanwhile, and a new load entering WAIT_DATA while discard set ignores that one response.
REQ-015 SHALL ignore mem_resp_valid in EMPTY and HOLD (discard flag clear).

Reset
REQ-016 SHALL, on reset low, asynchronously enter EMPTY, clear discard flag, and hold out_valid=0; data registers need no reset.
REQ-017 SHALL, on reset mid-WAIT_DATA, not discard the first post-reset response.

Configuration
REQ-018 SHALL compile left/right support only when IO_LOAD_UNALIGNED_EN is defined; without it, load types 011/100 behave as word loads including alignment check.

Verification
REQ-019 Word load addr 0x1000, resp 0x89ABCDEF two cycles later, wb_allow_in=1 -> out_valid in resp cycle, out_result 0x89ABCDEF, strobe 0xF.
REQ-020 Signed byte addr 0x1003, resp 0x80FFFFFF -> out_result 0xFFFFFF80; unsigned -> 0x00000080.
REQ-021 Half load addr 0x1001 -> HOLD next cycle, no memory wait, out_exception=1, out_badvaddr 0x1001, strobe 0.
REQ-022 Left load addr 0x2001, resp 0x11223344 (macro defined) -> out_result 0x33440000, strobe 0xC; macro undefined -> exception.
REQ-023 Flush during WAIT_DATA, then new word load, stale resp 0xDEAD, then resp 0xBEEF -> only 0xBEEF presented.
REQ-024 Resp with wb_allow_in=0 for 3 cycles -> out_valid and out_result stable all 3 cycles, in_allow_in=0, accepted on 4th.
